// File: rtl/dea_pkg.sv
// Shared definitions for the byte-stream encryptor/decryptor pair.
// Holds the FSM state type, key-bank geometry and the data byte width.
package dea_pkg;

  localparam int unsigned KEY_DEPTH = 8;
  localparam int unsigned KEY_AW    = 3;
  localparam int unsigned BYTE_W    = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } dea_state_e;

  // Requested key count of 0 or anything above the bank depth means "use all keys".
  function automatic logic [KEY_AW:0] eff_key_count(input logic [KEY_AW:0] nk);
    if (nk == '0 || nk > (KEY_AW + 1)'(KEY_DEPTH)) begin
      return (KEY_AW + 1)'(KEY_DEPTH);
    end
    return nk;
  endfunction

endpackage

// File: rtl/dea_key_bank.sv
// Key bank: KEY_DEPTH x BYTE_W register file, one synchronous write port and one
// combinational read port. No reset; contents must be loaded before use.
// Ports:
//   clk_i    - clock
//   we_i     - write enable
//   waddr_i  - write index
//   wdata_i  - write data
//   raddr_i  - read index
//   rdata_o  - read data (combinational)
module dea_key_bank
  import dea_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [KEY_AW-1:0] waddr_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic [KEY_AW-1:0] raddr_i,
  output logic [BYTE_W-1:0] rdata_o
);

  logic [BYTE_W-1:0] mem_q [KEY_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/decryption_engine.sv
// XOR stream decryptor. Each accepted ciphertext byte is XORed with the current
// key-bank entry; the key index cycles through the active key count.
// Ports:
//   Clk, Reset            - clock, synchronous active-high reset
//   KeyWe/KeyAddr/KeyIn   - key-bank write (IDLE only)
//   NumberOfKeys          - active key count, 0 or >8 means 8 (sampled on Start)
//   SizeOfData            - message length in bytes (sampled on Start)
//   Start                 - begin message (IDLE only)
//   DataValid/DataIn      - ciphertext input, transfer on DataValid && DataReq
//   DataReq               - engine can accept a byte this cycle
//   DataOut/Ready/Ack     - plaintext output, transfer on Ready && Ack
//   Busy                  - not in IDLE
//   Done                  - one-cycle pulse after the last byte is acknowledged
module decryption_engine
  import dea_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              KeyWe,
  input  logic [KEY_AW-1:0] KeyAddr,
  input  logic [BYTE_W-1:0] KeyIn,
  input  logic [KEY_AW:0]   NumberOfKeys,
  input  logic [BYTE_W-1:0] SizeOfData,
  input  logic              Start,
  input  logic              DataValid,
  input  logic [BYTE_W-1:0] DataIn,
  output logic              DataReq,
  output logic [BYTE_W-1:0] DataOut,
  output logic              Ready,
  input  logic              Ack,
  output logic              Busy,
  output logic              Done
);

  dea_state_e        state_q, state_d;
  logic [BYTE_W-1:0] size_q, size_d;
  logic [KEY_AW:0]   nk_q, nk_d;
  logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [KEY_AW-1:0] key_idx_q, key_idx_d;
  logic [BYTE_W-1:0] data_out_q, data_out_d;
  logic              ready_q, ready_d;
  logic              data_req;
  logic              key_we;
  logic [BYTE_W-1:0] key;
  logic              key_last;

  dea_key_bank u_key_bank (
    .clk_i   (Clk),
    .we_i    (key_we),
    .waddr_i (KeyAddr),
    .wdata_i (KeyIn),
    .raddr_i (key_idx_q),
    .rdata_o (key)
  );

  assign key_last = ({1'b0, key_idx_q} == nk_q - {{KEY_AW{1'b0}}, 1'b1});

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    nk_d       = nk_q;
    byte_cnt_d = byte_cnt_q;
    key_idx_d  = key_idx_q;
    data_out_d = data_out_q;
    ready_d    = ready_q;
    data_req   = 1'b0;
    key_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        key_we = KeyWe;
        if (Start) begin
          size_d     = SizeOfData;
          nk_d       = eff_key_count(NumberOfKeys);
          byte_cnt_d = '0;
          key_idx_d  = '0;
          state_d    = (SizeOfData == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        // Single-entry output register: refillable in the cycle it is acked.
        data_req = !ready_q || Ack;
        if (DataValid && data_req) begin
          data_out_d = DataIn ^ key;
          ready_d    = 1'b1;
          byte_cnt_d = byte_cnt_q + BYTE_W'(1);
          key_idx_d  = key_last ? '0 : key_idx_q + KEY_AW'(1);
          if (byte_cnt_d == size_q) begin
            state_d = StDrain;
          end
        end else if (ready_q && Ack) begin
          ready_d = 1'b0;
        end
      end
      StDrain: begin
        if (ready_q && Ack) begin
          ready_d = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      size_q     <= '0;
      nk_q       <= '0;
      byte_cnt_q <= '0;
      key_idx_q  <= '0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      nk_q       <= nk_d;
      byte_cnt_q <= byte_cnt_d;
      key_idx_q  <= key_idx_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
    end
  end

  assign DataReq = data_req;
  assign DataOut = data_out_q;
  assign Ready   = ready_q;
  assign Busy    = (state_q != StIdle);
  assign Done    = (state_q == StDone);

endmodule

// File: tb/tb_decryption_engine.sv
module tb_decryption_engine;

  logic       Clk;
  logic       Reset;
  logic       KeyWe;
  logic [2:0] KeyAddr;
  logic [7:0] KeyIn;
  logic [3:0] NumberOfKeys;
  logic [7:0] SizeOfData;
  logic       Start;
  logic       DataValid;
  logic [7:0] DataIn;
  logic       DataReq;
  logic [7:0] DataOut;
  logic       Ready;
  logic       Ack;
  logic       Busy;
  logic       Done;

  decryption_engine dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .KeyWe        (KeyWe),
    .KeyAddr      (KeyAddr),
    .KeyIn        (KeyIn),
    .NumberOfKeys (NumberOfKeys),
    .SizeOfData   (SizeOfData),
    .Start        (Start),
    .DataValid    (DataValid),
    .DataIn       (DataIn),
    .DataReq      (DataReq),
    .DataOut      (DataOut),
    .Ready        (Ready),
    .Ack          (Ack),
    .Busy         (Busy),
    .Done         (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] kbuf [8];
  logic [7:0] tx [256];
  logic [7:0] rx [256];
  logic [7:0] exp_b [256];
  int         rx_cyc [256];
  int         in_i, rx_cnt, done_cnt, done_cyc, last_ack;
  bit         st_req, st_chg;

  task automatic load_keys(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      KeyWe   = 1'b1;
      KeyAddr = 3'(i);
      KeyIn   = kbuf[i];
    end
    @(negedge Clk);
    KeyWe = 1'b0;
  endtask

  task automatic start_msg(input int size, input int nk);
    @(negedge Clk);
    Start        = 1'b1;
    SizeOfData   = 8'(size);
    NumberOfKeys = 4'(nk);
    DataValid    = 1'b0;
    Ack          = 1'b0;
  endtask

  // Streams tx[0..n-1] in, collects acknowledged outputs; Ack held high except for
  // an ack_low-cycle stall beginning when the first byte becomes Ready.
  task automatic run_msg(input int n, input int ack_low, input bit poke);
    int         stall;
    bit         stalled_once;
    logic [7:0] stall_out;
    stall = 0; stalled_once = 0; stall_out = 8'h00;
    in_i = 0; rx_cnt = 0; done_cnt = 0; done_cyc = -1; last_ack = -1;
    st_req = 0; st_chg = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge Clk);
      Start = 1'b0;
      KeyWe = 1'b0;
      if (poke && cyc == 2) begin
        KeyWe = 1'b1; KeyAddr = 3'd0; KeyIn = 8'hEE;
        Start = 1'b1; SizeOfData = 8'd1;
      end
      DataValid = (in_i < n);
      DataIn    = (in_i < n) ? tx[in_i] : 8'h00;
      if (Ready && !stalled_once && ack_low > 0) begin
        stall = ack_low; stalled_once = 1; stall_out = DataOut;
      end
      Ack = (stall == 0);
      #1;
      if (stall > 0) begin
        if (DataReq) st_req = 1;
        if (DataOut !== stall_out || !Ready) st_chg = 1;
        stall--;
      end
      if (DataValid && DataReq) in_i++;
      if (Ready && Ack && rx_cnt < 256) begin
        rx[rx_cnt] = DataOut; rx_cyc[rx_cnt] = cyc; rx_cnt++; last_ack = cyc;
      end
      if (Done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc > done_cyc + 2) break;
    end
    @(negedge Clk);
    DataValid = 1'b0; Ack = 1'b0; Start = 1'b0; KeyWe = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++; if (DataOut !== 8'h00) begin n_errors++; $display("FAIL reset_dataout: got %h expected 00", DataOut); end
    n_checks++; if (Ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b expected 0", Ready); end
    n_checks++; if (DataReq !== 1'b0) begin n_errors++; $display("FAIL reset_datareq: got %b expected 0", DataReq); end
    n_checks++; if (Busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    n_checks++; if (Done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", Done); end
  endtask

  task automatic test_basic;
    kbuf[0] = 8'hA5;
    load_keys(1);
    tx[0] = 8'h00; tx[1] = 8'hFF; tx[2] = 8'h5A;
    exp_b[0] = 8'hA5; exp_b[1] = 8'h5A; exp_b[2] = 8'hFF;
    start_msg(3, 1);
    run_msg(3, 0, 0);
    n_checks++; if (rx_cnt != 3) begin n_errors++; $display("FAIL basic_count: got %0d expected 3", rx_cnt); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rx[i] !== exp_b[i]) begin n_errors++; $display("FAIL basic_byte%0d: got %h expected %h", i, rx[i], exp_b[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (rx_cyc[i + 1] != rx_cyc[i] + 1) begin
        n_errors++; $display("FAIL basic_consecutive%0d: got cycle %0d expected %0d", i, rx_cyc[i + 1], rx_cyc[i] + 1);
      end
    end
    n_checks++; if (done_cnt != 1) begin n_errors++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
    n_checks++; if (done_cyc != last_ack + 1) begin n_errors++; $display("FAIL basic_done_timing: got cycle %0d expected %0d", done_cyc, last_ack + 1); end
  endtask

  task automatic test_wrap;
    kbuf[0] = 8'h01; kbuf[1] = 8'h02; kbuf[2] = 8'h03;
    load_keys(3);
    for (int i = 0; i < 5; i++) tx[i] = 8'h00;
    exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h03; exp_b[3] = 8'h01; exp_b[4] = 8'h02;
    start_msg(5, 3);
    run_msg(5, 0, 1);  // KeyWe and Start pulsed mid-message must be ignored
    n_checks++; if (rx_cnt != 5) begin n_errors++; $display("FAIL wrap_count: got %0d expected 5", rx_cnt); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rx[i] !== exp_b[i]) begin n_errors++; $display("FAIL wrap_byte%0d: got %h expected %h", i, rx[i], exp_b[i]); end
    end
    n_checks++; if (done_cnt != 1) begin n_errors++; $display("FAIL wrap_done_count: got %0d expected 1", done_cnt); end
    // Bank retained, and key 0 not overwritten by the ignored mid-run write.
    start_msg(3, 3);
    run_msg(3, 0, 0);
    n_checks++; if (rx_cnt != 3) begin n_errors++; $display("FAIL retain_count: got %0d expected 3", rx_cnt); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rx[i] !== exp_b[i]) begin n_errors++; $display("FAIL retain_byte%0d: got %h expected %h", i, rx[i], exp_b[i]); end
    end
  endtask

  task automatic test_back_pressure;
    tx[0] = 8'h10; tx[1] = 8'h20; tx[2] = 8'h30; tx[3] = 8'h40; tx[4] = 8'h50;
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h41; exp_b[4] = 8'h52;
    start_msg(5, 3);
    run_msg(5, 4, 0);
    n_checks++; if (st_req !== 1'b0) begin n_errors++; $display("FAIL bp_datareq: got %b expected 0", st_req); end
    n_checks++; if (st_chg !== 1'b0) begin n_errors++; $display("FAIL bp_dataout_stable: got changed=%b expected 0", st_chg); end
    n_checks++; if (rx_cnt != 5) begin n_errors++; $display("FAIL bp_count: got %0d expected 5", rx_cnt); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rx[i] !== exp_b[i]) begin n_errors++; $display("FAIL bp_byte%0d: got %h expected %h", i, rx[i], exp_b[i]); end
    end
    n_checks++; if (done_cnt != 1) begin n_errors++; $display("FAIL bp_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_zero_size;
    start_msg(0, 1);
    @(negedge Clk);
    Start = 1'b0;
    #1;
    n_checks++; if (Busy !== 1'b1) begin n_errors++; $display("FAIL zero_busy: got %b expected 1", Busy); end
    n_checks++; if (Done !== 1'b1) begin n_errors++; $display("FAIL zero_done: got %b expected 1", Done); end
    n_checks++; if (Ready !== 1'b0) begin n_errors++; $display("FAIL zero_ready: got %b expected 0", Ready); end
    @(negedge Clk);
    #1;
    n_checks++; if (Busy !== 1'b0) begin n_errors++; $display("FAIL zero_idle_busy: got %b expected 0", Busy); end
    n_checks++; if (Done !== 1'b0) begin n_errors++; $display("FAIL zero_done_pulse: got %b expected 0", Done); end
  endtask

  task automatic test_round_trip;
    kbuf[0] = 8'h3C; kbuf[1] = 8'hC3;
    load_keys(2);
    for (int i = 0; i < 16; i++) begin
      exp_b[i] = 8'(i * 17 + 3);          // plaintext
      tx[i]    = exp_b[i] ^ kbuf[i % 2];  // encryptor output
    end
    start_msg(16, 2);
    run_msg(16, 0, 0);
    n_checks++; if (rx_cnt != 16) begin n_errors++; $display("FAIL rt_count: got %0d expected 16", rx_cnt); end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (rx[i] !== exp_b[i]) begin n_errors++; $display("FAIL rt_byte%0d: got %h expected %h", i, rx[i], exp_b[i]); end
    end
  endtask

  task automatic test_long;
    kbuf[0] = 8'h11; kbuf[1] = 8'h22; kbuf[2] = 8'h33; kbuf[3] = 8'h44;
    kbuf[4] = 8'h55; kbuf[5] = 8'h66; kbuf[6] = 8'h77; kbuf[7] = 8'h88;
    load_keys(8);
    for (int i = 0; i < 255; i++) begin
      tx[i]    = 8'(i);
      exp_b[i] = 8'(i) ^ kbuf[i % 8];
    end
    start_msg(255, 0);  // zero key count means all 8
    run_msg(255, 0, 0);
    n_checks++; if (rx_cnt != 255) begin n_errors++; $display("FAIL long_count: got %0d expected 255", rx_cnt); end
    n_checks++; if (done_cnt != 1) begin n_errors++; $display("FAIL long_done_count: got %0d expected 1", done_cnt); end
    for (int i = 0; i < 255; i++) begin
      n_checks++;
      if (rx[i] !== exp_b[i]) begin n_errors++; $display("FAIL long_byte%0d: got %h expected %h", i, rx[i], exp_b[i]); end
    end
    for (int i = 0; i < 10; i++) begin
      tx[i]    = 8'h00;
      exp_b[i] = kbuf[i % 8];
    end
    start_msg(10, 9);  // above the bank depth also means 8
    run_msg(10, 0, 0);
    n_checks++; if (rx_cnt != 10) begin n_errors++; $display("FAIL nk9_count: got %0d expected 10", rx_cnt); end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (rx[i] !== exp_b[i]) begin n_errors++; $display("FAIL nk9_byte%0d: got %h expected %h", i, rx[i], exp_b[i]); end
    end
  endtask

  task automatic test_reset_mid;
    bit done_seen;
    kbuf[0] = 8'hA5;
    load_keys(1);
    start_msg(3, 1);
    @(negedge Clk);
    Start = 1'b0; DataValid = 1'b1; DataIn = 8'h11; Ack = 1'b0;
    @(negedge Clk);
    DataValid = 1'b0;
    n_checks++; if (Ready !== 1'b1) begin n_errors++; $display("FAIL rst_mid_pre_ready: got %b expected 1", Ready); end
    Reset = 1'b1; Start = 1'b1; KeyWe = 1'b1; Ack = 1'b1; DataValid = 1'b1;
    @(negedge Clk);
    Reset = 1'b0; Start = 1'b0; KeyWe = 1'b0; Ack = 1'b0; DataValid = 1'b0;
    #1;
    n_checks++; if (Busy !== 1'b0) begin n_errors++; $display("FAIL rst_mid_busy: got %b expected 0", Busy); end
    n_checks++; if (Ready !== 1'b0) begin n_errors++; $display("FAIL rst_mid_ready: got %b expected 0", Ready); end
    n_checks++; if (DataOut !== 8'h00) begin n_errors++; $display("FAIL rst_mid_dataout: got %h expected 00", DataOut); end
    n_checks++; if (DataReq !== 1'b0) begin n_errors++; $display("FAIL rst_mid_datareq: got %b expected 0", DataReq); end
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (Done) done_seen = 1;
      @(negedge Clk);
      #1;
    end
    n_checks++; if (done_seen !== 1'b0) begin n_errors++; $display("FAIL rst_mid_no_done: got %b expected 0", done_seen); end
    kbuf[0] = 8'h5C;
    load_keys(1);
    tx[0] = 8'h00; tx[1] = 8'h0F;
    start_msg(2, 1);
    run_msg(2, 0, 0);
    n_checks++; if (rx_cnt != 2) begin n_errors++; $display("FAIL rst_after_count: got %0d expected 2", rx_cnt); end
    n_checks++; if (rx[0] !== 8'h5C) begin n_errors++; $display("FAIL rst_after_byte0: got %h expected 5c", rx[0]); end
    n_checks++; if (rx[1] !== 8'h53) begin n_errors++; $display("FAIL rst_after_byte1: got %h expected 53", rx[1]); end
    n_checks++; if (done_cnt != 1) begin n_errors++; $display("FAIL rst_after_done: got %0d expected 1", done_cnt); end
  endtask

  initial begin
    Reset = 1'b1; KeyWe = 1'b0; KeyAddr = 3'd0; KeyIn = 8'h00;
    NumberOfKeys = 4'd1; SizeOfData = 8'd0; Start = 1'b0;
    DataValid = 1'b0; DataIn = 8'h00; Ack = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    #1;
    test_reset;
    test_basic;
    test_wrap;
    test_back_pressure;
    test_zero_size;
    test_round_trip;
    test_long;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
